// File: rtl/a51_ctrl_if.sv
// Handshake and LFSR-facing signal bundle for the A5/1 sequencing controller.
// The master side is the host plus the LFSR stages; the slave side is a51_ctrl.
interface a51_ctrl_if;
  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        ks_req;
  logic        r1_tap;
  logic        r2_tap;
  logic        r3_tap;
  logic        r1_msb;
  logic        r2_msb;
  logic        r3_msb;
  logic        lfsr_rst_n;
  logic        shift_bit;
  logic        trigger1;
  logic        trigger2;
  logic        trigger3;
  logic        busy;
  logic        ks_bit;
  logic        ks_valid;
  logic        done;

  modport master (
    output start, key, frame, ks_req,
    output r1_tap, r2_tap, r3_tap, r1_msb, r2_msb, r3_msb,
    input  lfsr_rst_n, shift_bit, trigger1, trigger2, trigger3,
    input  busy, ks_bit, ks_valid, done
  );

  modport slave (
    input  start, key, frame, ks_req,
    input  r1_tap, r2_tap, r3_tap, r1_msb, r2_msb, r3_msb,
    output lfsr_rst_n, shift_bit, trigger1, trigger2, trigger3,
    output busy, ks_bit, ks_valid, done
  );
endinterface

// File: rtl/a51_ctrl.sv
// A5/1 session sequencer: clears the three LFSRs, loads key and frame, runs
// 100 majority-clocked mixing steps, then emits KS_LEN keystream steps.
module a51_ctrl #(
  parameter int KS_LEN = 228
) (
  input logic     clk,
  input logic     reset,
  a51_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_KEY, S_FRAME, S_MIX, S_KS, S_DONE
  } state_t;

  localparam logic [7:0] KS_LAST = 8'(KS_LEN - 1);

  state_t      state_q, state_d;
  logic [6:0]  phase_q, phase_d;
  logic [7:0]  ks_cnt_q, ks_cnt_d;
  logic [63:0] key_q;
  logic [21:0] frame_q;
  logic        lfsr_rst_n_q;
  logic        ks_valid_q;
  logic        done_q;

  logic        maj;
  logic [2:0]  maj_trig;
  logic [2:0]  trig;
  logic        shift_bit;
  logic        ks_step;
  logic        load_en;

  assign maj = (bus.r1_tap & bus.r2_tap) | (bus.r1_tap & bus.r3_tap) |
               (bus.r2_tap & bus.r3_tap);
  assign maj_trig = {bus.r1_tap == maj, bus.r2_tap == maj, bus.r3_tap == maj};

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 7'd1;
    ks_cnt_d  = ks_cnt_q;
    trig      = 3'b000;
    shift_bit = 1'b0;
    ks_step   = 1'b0;
    load_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load_en = 1'b1;
          state_d = S_CLR;
        end
      end
      S_CLR: state_d = S_KEY;
      S_KEY: begin
        trig      = 3'b111;
        shift_bit = key_q[phase_q[5:0]];
        if (phase_q == 7'd63) state_d = S_FRAME;
      end
      S_FRAME: begin
        trig      = 3'b111;
        shift_bit = frame_q[phase_q[4:0]];
        if (phase_q == 7'd21) state_d = S_MIX;
      end
      S_MIX: begin
        trig = maj_trig;
        if (phase_q == 7'd99) begin
          state_d  = S_KS;
          ks_cnt_d = 8'd0;
        end
      end
      S_KS: begin
        // Backpressure simply withholds the step; the counter tracks taken steps only.
        if (bus.ks_req) begin
          trig     = maj_trig;
          ks_step  = 1'b1;
          ks_cnt_d = ks_cnt_q + 8'd1;
          if (ks_cnt_q == KS_LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) phase_d = 7'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= 7'd0;
      ks_cnt_q     <= 8'd0;
      lfsr_rst_n_q <= 1'b0;
      ks_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      ks_cnt_q     <= ks_cnt_d;
      lfsr_rst_n_q <= (state_d != S_CLR);
      ks_valid_q   <= ks_step;
      done_q       <= (state_d == S_DONE);
    end
  end

  // Session operands are plain data: captured on an accepted start, never reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      key_q   <= bus.key;
      frame_q <= bus.frame;
    end
  end

  assign bus.lfsr_rst_n = lfsr_rst_n_q;
  assign bus.shift_bit  = shift_bit;
  assign bus.trigger1   = trig[2];
  assign bus.trigger2   = trig[1];
  assign bus.trigger3   = trig[0];
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.ks_bit     = bus.r1_msb ^ bus.r2_msb ^ bus.r3_msb;
  assign bus.ks_valid   = ks_valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_a51_ctrl.sv
// Directed bench for a51_ctrl: models the three LFSR stages and checks the
// session schedule and keystream against a software A5/1 reference.
module tb_a51_ctrl;
  localparam int KS_LEN = 228;

  logic clk = 1'b0;
  logic reset;
  a51_ctrl_if bus();

  a51_ctrl #(.KS_LEN(KS_LEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [18:0] r1;
  logic [21:0] r2;
  logic [22:0] r3;
  logic        force_en;
  logic [2:0]  force_taps;
  logic [2:0]  trigs;

  always @(posedge clk) begin
    if (!bus.lfsr_rst_n) begin
      r1 <= '0; r2 <= '0; r3 <= '0;
    end else begin
      if (bus.trigger1) r1 <= {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ bus.shift_bit};
      if (bus.trigger2) r2 <= {r2[20:0], r2[21] ^ r2[20] ^ bus.shift_bit};
      if (bus.trigger3) r3 <= {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ bus.shift_bit};
    end
  end

  assign bus.r1_tap = force_en ? force_taps[2] : r1[8];
  assign bus.r2_tap = force_en ? force_taps[1] : r2[10];
  assign bus.r3_tap = force_en ? force_taps[0] : r3[10];
  assign bus.r1_msb = r1[18];
  assign bus.r2_msb = r2[21];
  assign bus.r3_msb = r3[22];
  assign trigs = {bus.trigger1, bus.trigger2, bus.trigger3};

  int n_vec = 0;
  int n_err = 0;
  bit gold [0:255];
  bit got  [0:255];
  int nvalid, first_valid, done_cycle, ndone, nreq_ks;
  int v_load, v_mix, v_ks, v_busy;
  bit clr_low, timed_out;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  task automatic make_gold(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic m, in, t1, t2, t3;
    a = '0; b = '0; c = '0;
    for (int i = 0; i < 186 + KS_LEN; i++) begin
      in = (i < 64) ? k[i] : (i < 86) ? f[i-64] : 1'b0;
      if (i < 86) begin
        t1 = 1'b1; t2 = 1'b1; t3 = 1'b1;
      end else begin
        m  = maj3(a[8], b[10], c[10]);
        t1 = (a[8] == m); t2 = (b[10] == m); t3 = (c[10] == m);
      end
      if (t1) a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ in};
      if (t2) b = {b[20:0], b[21] ^ b[20] ^ in};
      if (t3) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ in};
      if (i >= 186) gold[i-186] = a[18] ^ b[21] ^ c[22];
    end
  endtask

  // Runs one session from start (edge 0) to the done cycle, recording observations.
  task automatic run_session(input logic [63:0] k, input logic [21:0] f,
                             input bit bp, input bit busy_starts, input bit hold_start);
    int steps, exp_done;
    bit prev_step, step_now, exp_sb;
    logic m;
    logic [2:0] et;
    nvalid = 0; first_valid = -1; done_cycle = -1; ndone = 0; nreq_ks = 0;
    v_load = 0; v_mix = 0; v_ks = 0; v_busy = 0; clr_low = 0; timed_out = 1;
    steps = 0; exp_done = -1; prev_step = 0;
    @(posedge clk); #1;
    bus.key = k; bus.frame = f; bus.start = 1'b1; bus.ks_req = 1'b1;
    for (int c = 1; c <= 1200; c++) begin
      @(posedge clk); #1;
      bus.start = hold_start || (busy_starts && (c == 50 || c == 300));
      if (busy_starts && (c == 50 || c == 300)) begin
        bus.key = ~k; bus.frame = ~f;
      end
      bus.ks_req = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      step_now = 1'b0;
      if (c == 1) clr_low = (bus.lfsr_rst_n === 1'b0);
      if (bus.busy !== 1'b1) v_busy++;
      if (c >= 2 && c <= 87) begin
        exp_sb = (c <= 65) ? k[c-2] : f[c-66];
        if (bus.shift_bit !== exp_sb || trigs !== 3'b111) v_load++;
      end
      m  = maj3(bus.r1_tap, bus.r2_tap, bus.r3_tap);
      et = {bus.r1_tap == m, bus.r2_tap == m, bus.r3_tap == m};
      if (c >= 88 && c <= 187)
        if (trigs !== et || bus.shift_bit !== 1'b0) v_mix++;
      if (c >= 188) begin
        step_now = (steps < KS_LEN) && (bus.ks_req == 1'b1);
        if (step_now) nreq_ks++;
        if (trigs !== (step_now ? et : 3'b000) || bus.shift_bit !== 1'b0) v_ks++;
      end
      if (bus.ks_valid !== prev_step) v_ks++;
      if (bus.done !== (c == exp_done)) v_ks++;
      if (bus.ks_valid === 1'b1) begin
        if (nvalid == 0) first_valid = c;
        if (nvalid < 256) got[nvalid] = bus.ks_bit;
        nvalid++;
      end
      prev_step = step_now;
      if (step_now) begin
        steps++;
        if (steps == KS_LEN) exp_done = c + 1;
      end
      if (bus.done === 1'b1) begin
        ndone++; done_cycle = c; timed_out = 0;
        break;
      end
    end
    if (!hold_start) bus.start = 1'b0;
  endtask

  task automatic abort_with_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.ks_req = 1'b0; bus.key = '0; bus.frame = '0;
    force_en = 1'b0; force_taps = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.lfsr_rst_n, bus.busy, trigs, bus.ks_valid, bus.done, bus.shift_bit} !== 8'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b, want 00000000",
        {bus.lfsr_rst_n, bus.busy, trigs, bus.ks_valid, bus.done, bus.shift_bit});
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.lfsr_rst_n !== 1'b0) begin
      n_err++; $display("FAIL rst_n_before_edge: got %b, want 0", bus.lfsr_rst_n);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.lfsr_rst_n !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rst_n_after_edge: got rst_n=%b busy=%b, want 1 0", bus.lfsr_rst_n, bus.busy);
    end
    // Start a session and abort it in the middle of KEY.
    bus.key = 64'hA5A5_0F0F_3C3C_FFFF; bus.frame = 22'h2AAAAA; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_vec++;
    if (trigs !== 3'b111 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL key_phase_pre: got trig=%b busy=%b, want 111 1", trigs, bus.busy);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.lfsr_rst_n, trigs, bus.busy, bus.ks_valid, bus.done} !== 7'b0) begin
      n_err++; $display("FAIL midkey_reset: got %b, want 0000000",
        {bus.lfsr_rst_n, trigs, bus.busy, bus.ks_valid, bus.done});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++; $display("FAIL held_reset_%0d: got done=%b busy=%b, want 0 0", i, bus.done, bus.busy);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.lfsr_rst_n !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL release_pre_edge: got rst_n=%b busy=%b, want 0 0", bus.lfsr_rst_n, bus.busy);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.lfsr_rst_n !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL release_idle: got rst_n=%b busy=%b done=%b, want 1 0 0",
        bus.lfsr_rst_n, bus.busy, bus.done);
    end
  endtask

  task automatic test_schedule();
    int mism;
    make_gold(64'hFFFF_FFFF_FFFF_FFFF, 22'h3FFFFF);
    run_session(64'hFFFF_FFFF_FFFF_FFFF, 22'h3FFFFF, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (timed_out !== 1'b0) begin n_err++; $display("FAIL sched_timeout: got %b, want 0", timed_out); end
    n_vec++;
    if (clr_low !== 1'b1) begin n_err++; $display("FAIL sched_clr_cycle1: got %b, want 1", clr_low); end
    n_vec++;
    if (v_load !== 0) begin n_err++; $display("FAIL sched_load_cycles: got %0d bad cycles, want 0", v_load); end
    n_vec++;
    if (v_mix !== 0) begin n_err++; $display("FAIL sched_mix: got %0d bad cycles, want 0", v_mix); end
    n_vec++;
    if (v_ks !== 0) begin n_err++; $display("FAIL sched_ks_timing: got %0d bad cycles, want 0", v_ks); end
    n_vec++;
    if (v_busy !== 0) begin n_err++; $display("FAIL sched_busy: got %0d low cycles, want 0", v_busy); end
    n_vec++;
    if (first_valid !== 189) begin n_err++; $display("FAIL sched_first_valid: got %0d, want 189", first_valid); end
    n_vec++;
    if (nvalid !== KS_LEN) begin n_err++; $display("FAIL sched_valid_count: got %0d, want %0d", nvalid, KS_LEN); end
    n_vec++;
    if (done_cycle !== 416) begin n_err++; $display("FAIL sched_done_cycle: got %0d, want 416", done_cycle); end
    mism = 0;
    for (int i = 0; i < KS_LEN; i++) if (got[i] !== gold[i]) mism++;
    n_vec++;
    if (mism !== 0) begin n_err++; $display("FAIL sched_bits: got %0d wrong bits, want 0", mism); end
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL sched_post_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_majority();
    bus.key = 64'h0123_4567_89AB_CDEF; bus.frame = 22'h155555;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    force_en = 1'b1; force_taps = 3'b110; #1;
    n_vec++;
    if (trigs !== 3'b110) begin n_err++; $display("FAIL maj_110: got %b, want 110", trigs); end
    force_taps = 3'b010; #1;
    n_vec++;
    if (trigs !== 3'b101) begin n_err++; $display("FAIL maj_010: got %b, want 101", trigs); end
    force_taps = 3'b111; #1;
    n_vec++;
    if (trigs !== 3'b111) begin n_err++; $display("FAIL maj_111: got %b, want 111", trigs); end
    force_taps = 3'b001; #1;
    n_vec++;
    if (trigs !== 3'b110) begin n_err++; $display("FAIL maj_001: got %b, want 110", trigs); end
    force_en = 1'b0;
    abort_with_reset();
  endtask

  task automatic test_known_answer();
    int ones, mism;
    run_session(64'h0, 22'h0, 1'b0, 1'b0, 1'b0);
    ones = 0;
    for (int i = 0; i < KS_LEN; i++) if (got[i] !== 1'b0) ones++;
    n_vec++;
    if (nvalid !== KS_LEN || ones !== 0) begin
      n_err++; $display("FAIL kat_zero: got count=%0d nonzero=%0d, want %0d 0", nvalid, ones, KS_LEN);
    end
    make_gold(64'h1223_4567_89AB_CDEF, 22'h134);
    run_session(64'h1223_4567_89AB_CDEF, 22'h134, 1'b0, 1'b0, 1'b0);
    mism = 0;
    for (int i = 0; i < KS_LEN; i++) if (got[i] !== gold[i]) mism++;
    n_vec++;
    if (nvalid !== KS_LEN || mism !== 0 || timed_out !== 1'b0) begin
      n_err++; $display("FAIL kat_ref: got count=%0d wrong=%0d timeout=%b, want %0d 0 0",
        nvalid, mism, timed_out, KS_LEN);
    end
  endtask

  task automatic test_backpressure();
    int mism;
    run_session(64'h1223_4567_89AB_CDEF, 22'h134, 1'b1, 1'b0, 1'b0);
    mism = 0;
    for (int i = 0; i < KS_LEN; i++) if (got[i] !== gold[i]) mism++;
    n_vec++;
    if (timed_out !== 1'b0) begin n_err++; $display("FAIL bp_timeout: got %b, want 0", timed_out); end
    n_vec++;
    if (nvalid !== nreq_ks || nvalid !== KS_LEN) begin
      n_err++; $display("FAIL bp_count: got %0d valids, want %0d (req cycles %0d)", nvalid, KS_LEN, nreq_ks);
    end
    n_vec++;
    if (v_ks !== 0) begin n_err++; $display("FAIL bp_timing: got %0d bad cycles, want 0", v_ks); end
    n_vec++;
    if (mism !== 0) begin n_err++; $display("FAIL bp_bits: got %0d wrong bits, want 0", mism); end
  endtask

  task automatic test_busy_start();
    int mism, extra;
    run_session(64'h1223_4567_89AB_CDEF, 22'h134, 1'b0, 1'b1, 1'b0);
    mism = 0;
    for (int i = 0; i < KS_LEN; i++) if (got[i] !== gold[i]) mism++;
    n_vec++;
    if (mism !== 0 || nvalid !== KS_LEN) begin
      n_err++; $display("FAIL busy_bits: got wrong=%0d count=%0d, want 0 %0d", mism, nvalid, KS_LEN);
    end
    n_vec++;
    if (done_cycle !== 188 + KS_LEN || v_ks !== 0) begin
      n_err++; $display("FAIL busy_done: got cycle=%0d bad=%0d, want %0d 0", done_cycle, v_ks, 188 + KS_LEN);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    n_vec++;
    if (extra !== 0) begin n_err++; $display("FAIL busy_no_extra: got %0d active cycles, want 0", extra); end
  endtask

  task automatic test_back_to_back();
    run_session(64'h0F1E_2D3C_4B5A_6978, 22'h2C3A1, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (done_cycle !== 188 + KS_LEN || v_ks !== 0) begin
      n_err++; $display("FAIL b2b_first: got cycle=%0d bad=%0d, want %0d 0", done_cycle, v_ks, 188 + KS_LEN);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.lfsr_rst_n !== 1'b1) begin
      n_err++; $display("FAIL b2b_idle: got busy=%b rst_n=%b, want 0 1", bus.busy, bus.lfsr_rst_n);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.lfsr_rst_n !== 1'b0) begin
      n_err++; $display("FAIL b2b_rearm: got busy=%b rst_n=%b, want 1 0", bus.busy, bus.lfsr_rst_n);
    end
    abort_with_reset();
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_majority();
    test_known_answer();
    test_backpressure();
    test_busy_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
